// File: rtl/bcd_glyph_writer_pkg.sv
// Shared glyph codes, geometry constants and FSM state type for the BCD glyph writer.
package bcd_glyph_writer_pkg;

  typedef enum logic [3:0] {
    G_0, G_1, G_2, G_3, G_4, G_5, G_6, G_7, G_8, G_9,
    G_DOT, G_V, G_DASH
  } glyph_e;

  localparam int unsigned GLYPH_W       = 8;
  localparam int unsigned N_CHARS       = 4;
  localparam int unsigned FB_PAGE_BYTES = 128;

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  // Non-decimal nibbles render as a dash rather than garbage.
  function automatic glyph_e digit_glyph(input logic [3:0] nibble);
    return (nibble > 4'd9) ? G_DASH : glyph_e'(nibble);
  endfunction

endpackage

// File: rtl/font8x8_rom.sv
// 8x8 column-oriented font ROM with a registered output; bit0 of each column is the top pixel.
module font8x8_rom
  import bcd_glyph_writer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] code_i,
  input  logic [2:0] col_i,
  output logic [7:0] data_o
);

  logic [63:0] glyph_bits;
  logic [7:0]  data_d, data_q;

  // Column 0 sits in bits [7:0], column 7 in bits [63:56].
  always_comb begin
    glyph_bits = 64'h0;
    case (code_i)
      G_0:     glyph_bits = 64'h0000_3E45_4951_3E00;
      G_1:     glyph_bits = 64'h0000_0040_7F42_0000;
      G_2:     glyph_bits = 64'h0000_4649_5161_4200;
      G_3:     glyph_bits = 64'h0000_314B_4541_2100;
      G_4:     glyph_bits = 64'h0000_107F_1214_1800;
      G_5:     glyph_bits = 64'h0000_3945_4545_2700;
      G_6:     glyph_bits = 64'h0000_3049_494A_3C00;
      G_7:     glyph_bits = 64'h0000_0305_0971_0100;
      G_8:     glyph_bits = 64'h0000_3649_4949_3600;
      G_9:     glyph_bits = 64'h0000_1E29_4949_0600;
      G_DOT:   glyph_bits = 64'h0000_0000_6060_0000;
      G_V:     glyph_bits = 64'h0000_1F20_4020_1F00;
      G_DASH:  glyph_bits = 64'h0000_0808_0808_0800;
      default: glyph_bits = 64'h0;
    endcase
  end

  always_comb begin
    data_d = glyph_bits[{col_i, 3'b000} +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= 8'h00;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bcd_glyph_writer.sv
// Renders a packed-BCD reading as "D.DV" into the OLED frame buffer, one burst per change.
module bcd_glyph_writer
  import bcd_glyph_writer_pkg::*;
#(
  parameter int unsigned PAGE      = 2,
  parameter int unsigned COL_START = 40
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] bcd_in,
  output logic       wr_en,
  output logic [8:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [8:0] BaseAddr = 9'(PAGE * FB_PAGE_BYTES + COL_START);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  shown_bcd_q, shown_bcd_d;
  logic        shown_valid_q, shown_valid_d;
  logic        wr_en_q, wr_en_d;
  logic [8:0]  wr_addr_q, wr_addr_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        trigger;
  logic [3:0]  code;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= StIdle;
      idx_q         <= 5'd0;
      shown_bcd_q   <= 8'h00;
      shown_valid_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 9'd0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shown_bcd_q   <= shown_bcd_d;
      shown_valid_q <= shown_valid_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign trigger = !shown_valid_q || (bcd_in != shown_bcd_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (trigger) state_d = StWrite;
      StWrite: if (idx_q == 5'd31) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // wr_en/wr_addr are registered from the same idx that feeds the ROM, so they line up with
  // its registered data one cycle later.
  always_comb begin
    idx_d         = idx_q;
    shown_bcd_d   = shown_bcd_q;
    shown_valid_d = shown_valid_q;
    wr_en_d       = (state_q == StWrite);
    wr_addr_d     = wr_addr_q;
    busy_d        = (state_d != StIdle);
    frame_done_d  = (state_q == StDone);
    if (state_q == StIdle && trigger) begin
      shown_bcd_d   = bcd_in;
      shown_valid_d = 1'b1;
      idx_d         = 5'd0;
    end else if (state_q == StWrite) begin
      idx_d     = idx_q + 5'd1;
      wr_addr_d = BaseAddr + 9'(idx_q);
    end
  end

  always_comb begin
    code = G_DOT;
    unique case (idx_q[4:3])
      2'd0: code = digit_glyph(shown_bcd_q[7:4]);
      2'd1: code = G_DOT;
      2'd2: code = digit_glyph(shown_bcd_q[3:0]);
      2'd3: code = G_V;
    endcase
  end

  font8x8_rom u_font (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .code_i (code),
    .col_i  (idx_q[2:0]),
    .data_o (wr_data)
  );

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_glyph_writer.sv
// Randomised scoreboard bench for bcd_glyph_writer: default placement plus a page-0 / column-96 copy.
module tb_bcd_glyph_writer;

  typedef struct {
    int         edge_n;
    int         idx;
    logic [7:0] data;
  } exp_t;

  // Reference font, listed column 0 first; bit0 is the top pixel.
  localparam logic [7:0] FONT [13][8] = '{
    '{8'h00, 8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h42, 8'h61, 8'h51, 8'h49, 8'h46, 8'h00, 8'h00},
    '{8'h00, 8'h21, 8'h41, 8'h45, 8'h4B, 8'h31, 8'h00, 8'h00},
    '{8'h00, 8'h18, 8'h14, 8'h12, 8'h7F, 8'h10, 8'h00, 8'h00},
    '{8'h00, 8'h27, 8'h45, 8'h45, 8'h45, 8'h39, 8'h00, 8'h00},
    '{8'h00, 8'h3C, 8'h4A, 8'h49, 8'h49, 8'h30, 8'h00, 8'h00},
    '{8'h00, 8'h01, 8'h71, 8'h09, 8'h05, 8'h03, 8'h00, 8'h00},
    '{8'h00, 8'h36, 8'h49, 8'h49, 8'h49, 8'h36, 8'h00, 8'h00},
    '{8'h00, 8'h06, 8'h49, 8'h49, 8'h29, 8'h1E, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h60, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h1F, 8'h20, 8'h40, 8'h20, 8'h1F, 8'h00, 8'h00},
    '{8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00}
  };

  logic       clk = 1'b0;
  logic       rst_in;
  logic [7:0] bcd_in;

  logic       wr_en0, wr_en1, busy0, busy1, fd0, fd1;
  logic [8:0] addr0, addr1;
  logic [7:0] data0, data1;

  int errors = 0;
  int checks = 0;

  int base_addr [2] = '{296, 96};
  exp_t exp_q [2][$];

  int         cyc = 0;
  int         rst_edge = -1;
  int         next_cmp = 0;
  int         busy_lo = -1;
  int         busy_hi = -2;
  int         fd_edge = -1;
  logic       valid = 1'b0;
  logic [7:0] shown = 8'h00;

  always #5 clk = ~clk;

  bcd_glyph_writer u_dut0 (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .bcd_in     (bcd_in),
    .wr_en      (wr_en0),
    .wr_addr    (addr0),
    .wr_data    (data0),
    .busy       (busy0),
    .frame_done (fd0)
  );

  bcd_glyph_writer #(.PAGE(0), .COL_START(96)) u_dut1 (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .bcd_in     (bcd_in),
    .wr_en      (wr_en1),
    .wr_addr    (addr1),
    .wr_data    (data1),
    .busy       (busy1),
    .frame_done (fd1)
  );

  function automatic int char_code(input int ch, input logic [7:0] v);
    int hi = int'(v[7:4]);
    int lo = int'(v[3:0]);
    case (ch)
      0:       return (hi > 9) ? 12 : hi;
      1:       return 10;
      2:       return (lo > 9) ? 12 : lo;
      default: return 11;
    endcase
  endfunction

  // Reference model: a frame is "D.DV" starting one edge after it is triggered.
  always @(posedge clk) begin
    cyc++;
    if (rst_in) begin
      exp_q[0].delete();
      exp_q[1].delete();
      valid    = 1'b0;
      busy_lo  = -1;
      busy_hi  = -2;
      fd_edge  = -1;
      next_cmp = cyc + 1;
      rst_edge = cyc;
    end else if (cyc >= next_cmp && (!valid || bcd_in != shown)) begin
      shown    = bcd_in;
      valid    = 1'b1;
      busy_lo  = cyc;
      busy_hi  = cyc + 32;
      fd_edge  = cyc + 33;
      next_cmp = cyc + 34;
      for (int k = 0; k < 32; k++) begin
        exp_t ex;
        ex.edge_n = cyc + 1 + k;
        ex.idx    = k;
        ex.data   = FONT[char_code(k / 8, shown)][k % 8];
        exp_q[0].push_back(ex);
        exp_q[1].push_back(ex);
      end
    end
  end

  task automatic check_inst(input int i, input logic en, input logic [8:0] addr,
                            input logic [7:0] data, input logic bsy, input logic fd);
    logic exp_busy;
    if (rst_edge == cyc) begin
      checks++;
      if (en !== 1'b0 || addr !== 9'd0 || data !== 8'h00 || bsy !== 1'b0 || fd !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst%0d edge%0d: got en=%b addr=%0d data=%h busy=%b done=%b, want all 0",
                 i, cyc, en, addr, data, bsy, fd);
      end
      return;
    end
    if (en === 1'b1) begin
      checks++;
      if (exp_q[i].size() == 0) begin
        errors++;
        $display("FAIL unexpected_write inst%0d edge%0d: got addr=%0d data=%h, want no write",
                 i, cyc, addr, data);
      end else begin
        exp_t ex = exp_q[i].pop_front();
        if (ex.edge_n != cyc || addr !== 9'(base_addr[i] + ex.idx) || data !== ex.data) begin
          errors++;
          $display("FAIL write inst%0d: got edge%0d addr=%0d data=%h, want edge%0d addr=%0d data=%h",
                   i, cyc, addr, data, ex.edge_n, base_addr[i] + ex.idx, ex.data);
        end
      end
    end
    exp_busy = (cyc >= busy_lo && cyc <= busy_hi);
    checks++;
    if (bsy !== exp_busy) begin
      errors++;
      $display("FAIL busy inst%0d edge%0d: got %b want %b", i, cyc, bsy, exp_busy);
    end
    checks++;
    if (fd !== (cyc == fd_edge)) begin
      errors++;
      $display("FAIL frame_done inst%0d edge%0d: got %b want %b", i, cyc, fd, cyc == fd_edge);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      check_inst(0, wr_en0, addr0, data0, busy0, fd0);
      check_inst(1, wr_en1, addr1, data1, busy1, fd1);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_in = 1'b1;
    bcd_in = 8'h00;
    wait_cycles(3);
    rst_in = 1'b0;
    wait_cycles(40);
    bcd_in = 8'h33;
    wait_cycles(1040);
    bcd_in = 8'h44;
    wait_cycles(40);
    bcd_in = 8'h33;
    wait_cycles(5);
    bcd_in = 8'h12;
    wait_cycles(80);
    bcd_in = 8'h3A;
    wait_cycles(40);
    bcd_in = 8'h27;
    wait_cycles(10);
    rst_in = 1'b1;
    wait_cycles(3);
    rst_in = 1'b0;
    wait_cycles(40);
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 3) == 0) bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else if ($urandom_range(0, 3) != 0) bcd_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) begin
        rst_in = 1'b1;
        wait_cycles($urandom_range(1, 3));
        rst_in = 1'b0;
      end
      wait_cycles($urandom_range(1, 50));
    end
    wait_cycles(50);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL missing_writes inst%0d: got %0d pending, want 0", i, exp_q[i].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
